// File: rtl/uart_sys_ctrl_if.sv
// Command/response bus between the UART system controller and its RX, register
// file, ALU and TX FIFO neighbours.
interface uart_sys_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   rx_p_data;
  logic                    rx_d_vld;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic                    rf_wr_en;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic                    rf_rd_en;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_vld;
  logic                    alu_en;
  logic [3:0]              alu_fun;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_vld;
  logic [DATA_WIDTH-1:0]   tx_p_data;
  logic                    tx_d_vld;
  logic                    fifo_full;
  logic                    busy;
  logic                    cmd_err;

  modport master (
    input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_vld, alu_out, alu_out_vld, fifo_full,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_p_data, tx_d_vld,
           busy, cmd_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_vld, alu_out, alu_out_vld, fifo_full,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_p_data, tx_d_vld,
           busy, cmd_err
  );
endinterface

// File: rtl/uart_sys_ctrl.sv
// UART system controller: decodes RX command frames into register-file
// writes/reads and ALU operations, and streams results into the TX FIFO.
module uart_sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OPA_ADDR   = 0,
  parameter int OPB_ADDR   = 1
) (
  input logic             clk,
  input logic             rst,
  uart_sys_ctrl_if.master bus
);
  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND,
    OPA, OPB, FUN, ALU_WAIT, SEND_LO, SEND_HI
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
  logic [2*DATA_WIDTH-1:0] res_q, res_nx;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_nx;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_nx;
  logic [3:0]              fun_q, fun_nx;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_nx;
  logic                    wr_en_q, wr_en_nx;
  logic                    rd_en_q, rd_en_nx;
  logic                    alu_en_q, alu_en_nx;
  logic                    tx_vld_q, tx_vld_nx;
  logic                    err_q, err_nx;
  logic                    busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      res_q     <= '0;
      rf_addr_q <= '0;
      wr_data_q <= '0;
      fun_q     <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      res_q     <= res_nx;
      rf_addr_q <= rf_addr_nx;
      wr_data_q <= wr_data_nx;
      fun_q     <= fun_nx;
      tx_data_q <= tx_data_nx;
      wr_en_q   <= wr_en_nx;
      rd_en_q   <= rd_en_nx;
      alu_en_q  <= alu_en_nx;
      tx_vld_q  <= tx_vld_nx;
      err_q     <= err_nx;
      busy_q    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    addr_nx    = addr_q;
    res_nx     = res_q;
    rf_addr_nx = rf_addr_q;
    wr_data_nx = wr_data_q;
    fun_nx     = fun_q;
    tx_data_nx = tx_data_q;
    wr_en_nx   = 1'b0;
    rd_en_nx   = 1'b0;
    alu_en_nx  = 1'b0;
    tx_vld_nx  = 1'b0;
    err_nx     = 1'b0;
    unique case (state)
      IDLE: if (bus.rx_d_vld) begin
        if      (bus.rx_p_data == CMD_WR)     state_nx = WR_ADDR;
        else if (bus.rx_p_data == CMD_RD)     state_nx = RD_ADDR;
        else if (bus.rx_p_data == CMD_ALU_OP) state_nx = OPA;
        else if (bus.rx_p_data == CMD_ALU)    state_nx = FUN;
        else                                  err_nx   = 1'b1;
      end
      WR_ADDR: if (bus.rx_d_vld) begin
        addr_nx  = bus.rx_p_data[ADDR_WIDTH-1:0];
        state_nx = WR_DATA;
      end
      WR_DATA: if (bus.rx_d_vld) begin
        wr_en_nx   = 1'b1;
        rf_addr_nx = addr_q;
        wr_data_nx = bus.rx_p_data;
        state_nx   = IDLE;
      end
      RD_ADDR: if (bus.rx_d_vld) begin
        rd_en_nx   = 1'b1;
        rf_addr_nx = bus.rx_p_data[ADDR_WIDTH-1:0];
        state_nx   = RD_WAIT;
      end
      // A response coincident with the request strobe is too early to be ours.
      RD_WAIT: if (bus.rf_rd_vld && !rd_en_q) begin
        res_nx   = {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
        state_nx = RD_SEND;
      end
      RD_SEND: if (!bus.fifo_full) begin
        tx_vld_nx  = 1'b1;
        tx_data_nx = res_q[DATA_WIDTH-1:0];
        state_nx   = IDLE;
      end
      OPA: if (bus.rx_d_vld) begin
        wr_en_nx   = 1'b1;
        rf_addr_nx = ADDR_WIDTH'(OPA_ADDR);
        wr_data_nx = bus.rx_p_data;
        state_nx   = OPB;
      end
      OPB: if (bus.rx_d_vld) begin
        wr_en_nx   = 1'b1;
        rf_addr_nx = ADDR_WIDTH'(OPB_ADDR);
        wr_data_nx = bus.rx_p_data;
        state_nx   = FUN;
      end
      FUN: if (bus.rx_d_vld) begin
        alu_en_nx = 1'b1;
        fun_nx    = bus.rx_p_data[3:0];
        state_nx  = ALU_WAIT;
      end
      ALU_WAIT: if (bus.alu_out_vld && !alu_en_q) begin
        res_nx   = bus.alu_out;
        state_nx = SEND_LO;
      end
      SEND_LO: if (!bus.fifo_full) begin
        tx_vld_nx  = 1'b1;
        tx_data_nx = res_q[DATA_WIDTH-1:0];
        state_nx   = SEND_HI;
      end
      SEND_HI: if (!bus.fifo_full) begin
        tx_vld_nx  = 1'b1;
        tx_data_nx = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.rf_rd_en   = rd_en_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_fun    = fun_q;
  assign bus.tx_p_data  = tx_data_q;
  assign bus.tx_d_vld   = tx_vld_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_err    = err_q;
endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Directed bench for uart_sys_ctrl: expected RF writes and TX bytes are queued
// as commands are sent and checked as the controller emits them.
module tb_uart_sys_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_sys_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_sys_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .OPA_ADDR(0),
    .OPB_ADDR(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tx_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int alu_cnt = 0;
  int err_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then observe the strobes just after the edge.
  task automatic tick();
    logic [7:0]  e8;
    logic [11:0] e12;
    @(posedge clk);
    #1;
    if (bus.tx_d_vld) begin
      tx_cnt++;
      check("tx_expected", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) begin
        e8 = tx_q.pop_front();
        check("tx_byte", bus.tx_p_data, e8);
      end
    end
    if (bus.rf_wr_en) begin
      wr_cnt++;
      check("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        e12 = wr_q.pop_front();
        check("wr_addr_data", {bus.rf_addr, bus.rf_wr_data}, e12);
      end
    end
    if (bus.rf_rd_en) rd_cnt++;
    if (bus.alu_en)   alu_cnt++;
    if (bus.cmd_err)  err_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    tick();
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int target, input int max_cycles);
    int k;
    k = 0;
    while (tx_cnt < target && k < max_cycles) begin
      tick();
      k++;
    end
    check(tag, 32'(tx_cnt >= target), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_addr"}, bus.rf_addr, 0);
    check({tag, "_wr_data"}, bus.rf_wr_data, 0);
    check({tag, "_tx_data"}, bus.tx_p_data, 0);
    check({tag, "_alu_fun"}, bus.alu_fun, 0);
    check({tag, "_strobes"}, {bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.tx_d_vld, bus.cmd_err}, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int n, t, e;
    bus.rx_p_data   = '0;
    bus.rx_d_vld    = 1'b0;
    bus.rf_rd_data  = '0;
    bus.rf_rd_vld   = 1'b0;
    bus.alu_out     = '0;
    bus.alu_out_vld = 1'b0;
    bus.fifo_full   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    idle(2);

    // Write 0x3C to register 5
    wr_q.push_back({4'h5, 8'h3C});
    send(8'hAA);
    check("wr_busy", bus.busy, 1);
    idle(2);
    send(8'h05);
    idle(2);
    n = wr_cnt;
    send(8'h3C);
    check("wr_pulse", wr_cnt, n + 1);
    check("wr_busy_clr", bus.busy, 0);
    idle(3);
    check("wr_single", wr_cnt, n + 1);
    check("hold_addr", bus.rf_addr, 5);
    check("hold_data", bus.rf_wr_data, 8'h3C);

    // Read register 5 while the TX FIFO is full; early response must be ignored
    bus.fifo_full = 1'b1;
    tx_q.push_back(8'h3C);
    n = rd_cnt;
    send(8'hBB);
    idle(2);
    send(8'h05);
    check("rd_en", rd_cnt, n + 1);
    check("rd_addr", bus.rf_addr, 5);
    bus.rf_rd_vld  = 1'b1;
    bus.rf_rd_data = 8'hEE;
    tick();
    bus.rf_rd_data = 8'h3C;
    tick();
    bus.rf_rd_vld  = 1'b0;
    bus.rf_rd_data = '0;
    t = tx_cnt;
    idle(10);
    check("rd_full_hold", tx_cnt, t);
    check("rd_full_busy", bus.busy, 1);
    bus.fifo_full = 1'b0;
    wait_tx("rd_tx_timeout", t + 1, 5);
    idle(3);
    check("rd_tx_once", tx_cnt, t + 1);
    check("rd_busy_clr", bus.busy, 0);

    // ALU with operands: A=0x0A, B=0x03, fun=2, result 0x001E
    wr_q.push_back({4'h0, 8'h0A});
    wr_q.push_back({4'h1, 8'h03});
    tx_q.push_back(8'h1E);
    tx_q.push_back(8'h00);
    n = wr_cnt;
    t = tx_cnt;
    e = alu_cnt;
    send(8'hCC);
    idle(1);
    send(8'h0A);
    check("opa_wr", wr_cnt, n + 1);
    idle(1);
    send(8'h03);
    check("opb_wr", wr_cnt, n + 2);
    idle(1);
    send(8'h02);
    check("alu_en", alu_cnt, e + 1);
    check("alu_fun", bus.alu_fun, 2);
    bus.alu_out_vld = 1'b1;
    bus.alu_out     = 16'hBEEF;
    tick();
    bus.alu_out     = 16'h001E;
    tick();
    bus.alu_out_vld = 1'b0;
    wait_tx("alu_tx_timeout", t + 2, 10);
    check("alu_busy_clr", bus.busy, 0);

    // ALU without operands, stray RX byte while waiting, FIFO full between bytes
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hA5);
    n = wr_cnt;
    t = tx_cnt;
    e = err_cnt;
    send(8'hDD);
    idle(1);
    send(8'h01);
    check("alu2_fun", bus.alu_fun, 1);
    idle(2);
    send(8'h7E);
    idle(1);
    check("drop_no_err", err_cnt, e);
    check("drop_busy", bus.busy, 1);
    bus.alu_out     = 16'hA55A;
    bus.alu_out_vld = 1'b1;
    tick();
    bus.alu_out_vld = 1'b0;
    wait_tx("alu2_lo_timeout", t + 1, 5);
    bus.fifo_full = 1'b1;
    idle(6);
    check("alu2_hi_held", tx_cnt, t + 1);
    bus.fifo_full = 1'b0;
    wait_tx("alu2_hi_timeout", t + 2, 5);
    check("alu2_no_wr", wr_cnt, n);
    check("alu2_busy_clr", bus.busy, 0);

    // Unknown command, then a normal write
    e = err_cnt;
    send(8'h7E);
    check("err_pulse", bus.cmd_err, 1);
    check("err_idle", bus.busy, 0);
    tick();
    check("err_one_cycle", bus.cmd_err, 0);
    check("err_count", err_cnt, e + 1);
    wr_q.push_back({4'h2, 8'h11});
    n = wr_cnt;
    send(8'hAA);
    idle(1);
    send(8'h02);
    idle(1);
    send(8'h11);
    check("wr2_pulse", wr_cnt, n + 1);
    check("wr2_busy_clr", bus.busy, 0);

    // Reset in the middle of a write command
    send(8'hAA);
    idle(1);
    send(8'h04);
    check("mid_busy", bus.busy, 1);
    rst = 1'b0;
    #2;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    n = wr_cnt;
    e = err_cnt;
    send(8'h99);
    check("post_rst_err", bus.cmd_err, 1);
    idle(3);
    check("post_rst_no_wr", wr_cnt, n);
    check("post_rst_err_cnt", err_cnt, e + 1);
    check("post_rst_busy", bus.busy, 0);

    check("tx_q_drained", tx_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_sys_ctrl.md
# uart_sys_ctrl

System controller that sequences the register file, ALU and TX FIFO from command frames delivered by the UART receiver. Each validated RX byte (one-cycle `rx_d_vld` pulse) advances a command-decoding state machine that issues register writes and reads, loads ALU operands and launches ALU operations. Read and ALU results are pushed byte-wise into the UART TX FIFO. It sits between the UART RX/TX pair and the shared register file/ALU in the UART system top.

## Interface
- `DATA_WIDTH`, 8: RX/TX byte width and register width.
- `ADDR_WIDTH`, 4: register-file address width.
- `OPA_ADDR`, 0: register-file address that holds ALU operand A.
- `OPB_ADDR`, 1: register-file address that holds ALU operand B.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_p_data`  in  DATA_WIDTH  received byte, valid only while `rx_d_vld`=1.
- `rx_d_vld`  in  1  one-cycle pulse per good RX frame.
- `rf_addr`  out  ADDR_WIDTH  register-file address.
- `rf_wr_en`  out  1  register-file write strobe, one cycle.
- `rf_wr_data`  out  DATA_WIDTH  register-file write data.
- `rf_rd_en`  out  1  register-file read strobe, one cycle.
- `rf_rd_data`  in  DATA_WIDTH  read data.
- `rf_rd_vld`  in  1  read data valid pulse.
- `alu_en`  out  1  ALU start strobe, one cycle.
- `alu_fun`  out  4  ALU function code.
- `alu_out`  in  2*DATA_WIDTH  ALU result.
- `alu_out_vld`  in  1  ALU result valid pulse.
- `tx_p_data`  out  DATA_WIDTH  byte to TX FIFO.
- `tx_d_vld`  out  1  TX FIFO write strobe, one cycle.
- `fifo_full`  in  1  TX FIFO full.
- `busy`  out  1  high whenever state is not IDLE.
- `cmd_err`  out  1  one-cycle pulse on an unknown command byte.

## Operation
- Command bytes, decoded in IDLE: 0xAA = write (addr, data); 0xBB = read (addr); 0xCC = ALU with operands (A, B, fun); 0xDD = ALU without operands (fun).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, OPA, OPB, FUN, ALU_WAIT, SEND_LO, SEND_HI.
- IDLE: on `rx_d_vld`:
  - 0xAA → WR_ADDR.
  - 0xBB → RD_ADDR.
  - 0xCC → OPA.
  - 0xDD → FUN.
  - Any other byte → pulse `cmd_err`, stay in IDLE.
- WR_ADDR: on `rx_d_vld`, latch `rx_p_data[ADDR_WIDTH-1:0]` as address → WR_DATA.
- WR_DATA: on `rx_d_vld`, issue the write (latched addr, `rx_p_data`) → IDLE.
- RD_ADDR: on `rx_d_vld`, issue `rf_rd_en` with addr `rx_p_data[ADDR_WIDTH-1:0]` → RD_WAIT.
- RD_WAIT: on `rf_rd_vld`, latch `rf_rd_data` → RD_SEND.
- RD_SEND: when `fifo_full`=0, pulse `tx_d_vld` with the latched byte → IDLE.
- OPA: on `rx_d_vld`, write `rx_p_data` to `OPA_ADDR` → OPB.
- OPB: on `rx_d_vld`, write `rx_p_data` to `OPB_ADDR` → FUN.
- FUN: on `rx_d_vld`, pulse `alu_en` with `alu_fun`=`rx_p_data[3:0]` → ALU_WAIT.
- ALU_WAIT: on `alu_out_vld`, latch the 16-bit result → SEND_LO.
- SEND_LO: when `fifo_full`=0, send `result[7:0]` → SEND_HI.
- SEND_HI: when `fifo_full`=0, send `result[15:8]` → IDLE.
- `rx_d_vld` arriving in RD_WAIT, RD_SEND, ALU_WAIT, SEND_LO or SEND_HI is dropped: no state change, no `cmd_err`.
- Upper bits of address and function bytes are ignored.

## Timing
- All outputs are registered.
- A strobe (`rf_wr_en`, `rf_rd_en`, `alu_en`, `tx_d_vld`, `cmd_err`) is high for exactly the one cycle after the edge that sampled its triggering input. Its data/address/function outputs are valid in that same cycle.
- `rf_addr`, `rf_wr_data`, `alu_fun` and `tx_p_data` hold their last value when no strobe is active.
- `fifo_full` is sampled at the edge. If it is high, the send state waits indefinitely and the byte is not lost.
- `rf_rd_vld` or `alu_out_vld` arriving in the same cycle as the request strobe is not accepted; the response is taken from the next cycle onward.
- Reset, including mid-command: state goes to IDLE and every output is 0 (`rf_addr`, `rf_wr_data`, `tx_p_data`, `alu_fun`, strobes, `busy`, `cmd_err`). Partially received commands are discarded.
- Minimum command spacing is one RX frame. There is no throughput limit beyond waiting on the RF, ALU and FIFO.

## Test plan
- Write: RX 0xAA, 0x05, 0x3C → one `rf_wr_en` pulse with `rf_addr`=5, `rf_wr_data`=0x3C, then `busy`=0.
- Read with full FIFO: RX 0xBB, 0x05; return `rf_rd_data`=0x3C; hold `fifo_full`=1 for 10 cycles → no `tx_d_vld` while full; then exactly one `tx_d_vld` with 0x3C.
- ALU with operands: RX 0xCC, 0x0A, 0x03, 0x02; `alu_out`=0x001E → writes at addr 0 (0x0A) and addr 1 (0x03); `alu_en` with `alu_fun`=2; TX bytes 0x1E then 0x00.
- ALU without operands: RX 0xDD, 0x01; `alu_out`=0xA55A → no RF writes; TX 0x5A then 0xA5.
- Unknown command: RX 0x7E → one-cycle `cmd_err`, state stays IDLE. A following 0xAA, 0x02, 0x11 write completes normally.
- Mid-command reset: RX 0xAA, 0x04, assert `rst` → all outputs 0; after release, RX 0x99 → no write, `cmd_err` pulses.
